// File: rtl/remote_comm_if.sv
// Signal bundle between the remote-side command issuer and remote_comm.
// The slave modport is the remote_comm view; the master modport is the
// issuer/harness view (which also drives the robot's response line RX).
interface remote_comm_if;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        TX;
    logic        RX;
    logic        busy;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;
    logic        resp_timeout;

    modport master (
        output snd_cmd, cmd, RX, clr_resp_rdy,
        input  TX, busy, cmd_snt, resp, resp_rdy, resp_timeout
    );

    modport slave (
        input  snd_cmd, cmd, RX, clr_resp_rdy,
        output TX, busy, cmd_snt, resp, resp_rdy, resp_timeout
    );
endinterface

// File: rtl/remote_comm.sv
// remote_comm: host-side command sender. Sends a 16-bit command as two
// 8N1 UART bytes (high byte first), then waits for a one-byte response
// with a timeout. Contains its own UART transmitter and receiver.
module remote_comm #(
    parameter int RESP_TO_CYCLES = 1_000_000,
    parameter int BAUD_CYCLES    = 2604
) (
    input  logic         clk,
    input  logic         rst_n,
    remote_comm_if.slave bus
);
    localparam int TO_W   = $clog2(RESP_TO_CYCLES + 1);
    localparam int BAUD_W = $clog2(BAUD_CYCLES + 1);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RESP_TO_CYCLES - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_CYCLES / 2);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        WAIT_RESP
    } state_e;

    // ------------------------------------------------------------------
    // Command FSM signals
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [7:0]      low_q, low_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            cmd_snt_q, cmd_snt_d;
    logic            tx_first_q;
    logic            trmt;
    logic [7:0]      tx_data;

    // ------------------------------------------------------------------
    // UART transmitter signals
    // ------------------------------------------------------------------
    logic [9:0]        tx_shift_q;
    logic [3:0]        tx_bit_q;
    logic [BAUD_W-1:0] tx_baud_q;
    logic              tx_busy_q;
    logic              tx_done_q;

    // ------------------------------------------------------------------
    // UART receiver signals
    // ------------------------------------------------------------------
    logic [1:0]        rx_sync_q;
    logic              rx_busy_q;
    logic [BAUD_W-1:0] rx_baud_q;
    logic [3:0]        rx_bit_q;
    logic [7:0]        rx_shift_q;
    logic [7:0]        rx_data_q;
    logic              rx_rdy_q;
    logic              clr_rx_rdy;

    logic [7:0]        resp_q;
    logic              resp_rdy_q;

    // Transmitter: frame = start(0), 8 data bits LSB first, stop(1); the
    // shift register idles all-ones so its LSB is the line level directly.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_baud_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else if (trmt) begin
            tx_shift_q <= {1'b1, tx_data, 1'b0};
            tx_bit_q   <= '0;
            tx_baud_q  <= '0;
            tx_busy_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + BAUD_W'(1);
            end
        end
    end

    // Receiver: synchronise RX, find the start edge, sample mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], bus.RX};
            if (clr_rx_rdy) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_HALF;
                    rx_bit_q  <= '0;
                end
            end else if (rx_baud_q != '0) begin
                rx_baud_q <= rx_baud_q - BAUD_W'(1);
            end else begin
                rx_baud_q <= BAUD_LAST;
                if (rx_bit_q == 4'd9) begin
                    // Middle of the stop bit: byte complete.
                    rx_busy_q <= 1'b0;
                    rx_data_q <= rx_shift_q;
                    rx_rdy_q  <= 1'b1;
                end else if (rx_bit_q == 4'd0 && rx_sync_q[1]) begin
                    // Start bit gone high again: treat as a glitch.
                    rx_busy_q <= 1'b0;
                end else begin
                    if (rx_bit_q != 4'd0) begin
                        rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
                    end
                    rx_bit_q <= rx_bit_q + 4'd1;
                end
            end
        end
    end

    // The UART ready flag is consumed the same cycle it is seen.
    assign clr_rx_rdy = rx_rdy_q;

    // Response capture runs regardless of FSM state; a new byte beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else if (rx_rdy_q) begin
            resp_q     <= rx_data_q;
            resp_rdy_q <= 1'b1;
        end else if (bus.clr_resp_rdy) begin
            resp_rdy_q <= 1'b0;
        end
    end

    // Command FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            low_q      <= '0;
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            cmd_snt_q  <= 1'b0;
            tx_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
            cmd_snt_q  <= cmd_snt_d;
            tx_first_q <= trmt;
        end
    end

    // Command FSM next-state and UART launch decode. tx_first_q masks the
    // cycle right after trmt, when tx_done may not yet reflect the new byte.
    // NOTE: every output of this block is defaulted first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        cmd_snt_d = 1'b0;
        trmt      = 1'b0;
        tx_data   = bus.cmd[15:8];
        case (state_q)
            IDLE: begin
                if (bus.snd_cmd) begin
                    low_d     = bus.cmd[7:0];
                    tx_data   = bus.cmd[15:8];
                    trmt      = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (!tx_first_q && tx_done_q) begin
                    tx_data = low_q;
                    trmt    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (!tx_first_q && tx_done_q) begin
                    cmd_snt_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (rx_rdy_q) begin
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.TX           = tx_shift_q[0];
    assign bus.busy         = (state_q != IDLE);
    assign bus.cmd_snt      = cmd_snt_q;
    assign bus.resp         = resp_q;
    assign bus.resp_rdy     = resp_rdy_q;
    assign bus.resp_timeout = timeout_q;
endmodule

// File: tb/tb_remote_comm.sv
// Testbench for remote_comm: a behavioural UART peer decodes TX into a byte
// queue and serialises responses onto RX; expectations come from the
// command word, the response byte and the timeout rule.
module tb_remote_comm;
    localparam int RESP_TO = 100;
    localparam int BAUD    = 8;

    logic clk = 1'b0;
    logic rst_n;

    remote_comm_if bus();

    remote_comm #(
        .RESP_TO_CYCLES(RESP_TO),
        .BAUD_CYCLES   (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         errors      = 0;
    int         framing_err = 0;
    logic [7:0] mon_q[$];
    logic [7:0] last_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit idx in an 8N1 frame carrying b.
    function automatic logic rx_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Peer receiver on TX: find start, sample near bit centres.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.TX === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                if (bus.TX === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge clk);
                        b[i] = bus.TX;
                    end
                    repeat (BAUD) @(negedge clk);
                    if (bus.TX !== 1'b1) framing_err++;
                    mon_q.push_back(b);
                end
            end
        end
    end

    task automatic clear_rdy();
        bus.clr_resp_rdy = 1'b1;
        @(negedge clk);
        bus.clr_resp_rdy = 1'b0;
        check("clr_resp_rdy", bus.resp_rdy, 1'b0);
        check("resp_held", bus.resp, last_resp);
    endtask

    // One full command transaction; optional response starting d cycles
    // after cmd_snt; optional snd_cmd spam while the command is in flight.
    task automatic run_cmd(input logic [15:0] c, input bit do_resp, input int d,
                           input logic [7:0] rb, input bit spam, output int t_resp_o);
        int n;
        int t_resp;
        int t_to;
        bit exp_to;
        check("idle_before", bus.busy, 1'b0);
        mon_q.delete();
        bus.cmd     = c;
        bus.snd_cmd = 1'b1;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        bus.cmd     = 16'($urandom);
        check("busy_after_accept", bus.busy, 1'b1);
        check("timeout_cleared", bus.resp_timeout, 1'b0);
        n = 0;
        while (bus.cmd_snt !== 1'b1 && n < 30 * BAUD) begin
            if (spam) begin
                bus.snd_cmd = 1'($urandom_range(0, 1));
                bus.cmd     = 16'h1234;
            end
            @(negedge clk);
            n++;
        end
        bus.snd_cmd = 1'b0;
        check("cmd_snt_seen", bus.cmd_snt, 1'b1);
        t_resp = -1;
        t_to   = -1;
        for (int k = 1; k <= 140; k++) begin
            if (do_resp && k > d && k <= d + 10 * BAUD)
                bus.RX = rx_bit(rb, (k - d - 1) / BAUD);
            else
                bus.RX = 1'b1;
            @(negedge clk);
            if (k == 1) check("cmd_snt_width", bus.cmd_snt, 1'b0);
            if (bus.resp_rdy === 1'b1 && t_resp < 0) t_resp = k;
            if (bus.resp_timeout === 1'b1 && t_to < 0) t_to = k;
        end
        bus.RX = 1'b1;
        check("busy_done", bus.busy, 1'b0);
        check("tx_byte_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            check("tx_high_byte", mon_q[0], c[15:8]);
            check("tx_low_byte", mon_q[1], c[7:0]);
        end
        if (do_resp) begin
            exp_to = (t_resp > RESP_TO);
            check("resp_seen", t_resp > 0, 1'b1);
            check("resp_val", bus.resp, rb);
            check("resp_rdy", bus.resp_rdy, 1'b1);
            check("timeout_flag", bus.resp_timeout, exp_to);
            if (exp_to) check("timeout_at", t_to, RESP_TO);
            last_resp = rb;
        end else begin
            check("timeout_at", t_to, RESP_TO);
            check("timeout_flag", bus.resp_timeout, 1'b1);
            check("no_resp_rdy", bus.resp_rdy, 1'b0);
            check("resp_hold", bus.resp, last_resp);
        end
        t_resp_o = t_resp;
    endtask

    // Unsolicited byte while idle, optionally with clr_resp_rdy held high.
    task automatic send_idle_byte(input logic [7:0] b, input bit hold_clr);
        bit seen = 1'b0;
        bus.clr_resp_rdy = hold_clr;
        for (int k = 0; k < 10 * BAUD + 12; k++) begin
            bus.RX = (k < 10 * BAUD) ? rx_bit(b, k / BAUD) : 1'b1;
            @(negedge clk);
            if (bus.resp_rdy === 1'b1 && bus.resp === b) seen = 1'b1;
        end
        bus.clr_resp_rdy = 1'b0;
        check(hold_clr ? "rdy_set_wins" : "idle_resp_rdy", seen, 1'b1);
        check("idle_resp_val", bus.resp, b);
        check("idle_resp_rdy_end", bus.resp_rdy, !hold_clr);
        check("idle_busy", bus.busy, 1'b0);
        last_resp = b;
    endtask

    initial begin
        int  t;
        bit  hit;
        bit  snt_seen;
        bit  r_do;
        logic [7:0] r_b;

        rst_n            = 1'b0;
        bus.snd_cmd      = 1'b0;
        bus.cmd          = '0;
        bus.RX           = 1'b1;
        bus.clr_resp_rdy = 1'b0;
        last_resp        = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", bus.TX, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cmd_snt", bus.cmd_snt, 1'b0);
        check("rst_resp", bus.resp, 8'h00);
        check("rst_resp_rdy", bus.resp_rdy, 1'b0);
        check("rst_timeout", bus.resp_timeout, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic command with an answer, then clear the ready flag.
        run_cmd(16'hA55A, 1'b1, 5, 8'hA5, 1'b0, t);
        clear_rdy();

        // No answer: timeout.
        run_cmd(16'h3C96, 1'b0, 0, 8'h00, 1'b0, t);

        // Requests while busy are ignored; next command clears timeout.
        run_cmd(16'hBEEF, 1'b1, 3, 8'h5C, 1'b1, t);
        clear_rdy();

        // Reset halfway through the high byte.
        bus.cmd     = 16'hF00D;
        bus.snd_cmd = 1'b1;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        repeat (5 * BAUD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", bus.TX, 1'b1);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_cmd_snt", bus.cmd_snt, 1'b0);
        check("midrst_resp", bus.resp, 8'h00);
        last_resp = 8'h00;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        snt_seen = 1'b0;
        repeat (12 * BAUD) begin
            @(negedge clk);
            if (bus.cmd_snt === 1'b1) snt_seen = 1'b1;
        end
        check("no_snt_after_rst", snt_seen, 1'b0);
        check("tx_idle_after_rst", bus.TX, 1'b1);
        run_cmd(16'h0F0F, 1'b1, 0, 8'h77, 1'b0, t);

        // Unsolicited bytes; set beats clear.
        send_idle_byte(8'h3E, 1'b1);
        send_idle_byte(8'hC1, 1'b0);

        // Sweep response arrival across the timeout boundary.
        hit = 1'b0;
        for (int d = 12; d <= 28; d++) begin
            clear_rdy();
            run_cmd(16'($urandom), 1'b1, d, 8'($urandom), 1'b0, t);
            if (t == RESP_TO) hit = 1'b1;
        end
        check("boundary_hit", hit, 1'b1);

        // Randomised transactions.
        for (int i = 0; i < 12; i++) begin
            clear_rdy();
            r_do = 1'($urandom_range(0, 1));
            r_b  = 8'($urandom);
            run_cmd(16'($urandom), r_do, $urandom_range(0, 12), r_b,
                    1'($urandom_range(0, 1)), t);
        end

        repeat (2 * BAUD) @(negedge clk);
        check("framing", framing_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
